unidad_de_control: RTL and testbench
====================================

Name: unidad_de_control

Overview:
- Main decoder of the single-cycle datapath, with a bundled 2:1 32-bit data multiplexer.
- Decodes the 6-bit instruction opcode into registered control signals: MemToReg, MemToWrite, RegWrite, AluOp.
- Also provides a combinational 32-bit 2:1 selector used on the write-back/ALU-operand paths.

Parameters:
- DATA_W, 32, width of the multiplexer data inputs and output.
- OP_W, 6, opcode width.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset; asynchronous, active-low.
- op  input  6  instruction opcode field (instr[31:26]).
- MemToReg  output  1  1 = write-back data comes from memory.
- MemToWrite  output  1  1 = data memory write enable.
- RegWrite  output  1  1 = register file write enable.
- AluOp  output  2  ALU operation class for the ALU control block.
- op_illegal  output  1  1 = opcode not in the supported set.
- a  input  DATA_W  mux input 0.
- b  input  DATA_W  mux input 1.
- selector  input  1  mux select.
- salida  output  DATA_W  mux output.

Behaviour:
- Reset: while rst_n=0, MemToReg, MemToWrite, RegWrite and op_illegal are 0, and AluOp=2'b00. Reset assertion takes effect immediately, independent of clk.
- Control outputs are registered: on each rising clk edge with rst_n=1, they load the decode of the current op. Latency is 1 cycle and the outputs are stable between edges.
- Decode table (MemToReg, MemToWrite, RegWrite, AluOp, op_illegal):
  - 000000 R-type: 0,0,1,10,0
  - 100011 lw: 1,0,1,00,0
  - 101011 sw: 0,1,0,00,0
  - 000100 beq: 0,0,0,01,0
  - 001000 addi: 0,0,1,00,0
  - any other op: 0,0,0,00,1 (safe no-write default)
- No write enable is ever asserted for an illegal opcode.
- MemToWrite and RegWrite are never both 1.
- Reset release takes effect at the first rising edge after rst_n goes high. Reset asserted mid-operation clears the outputs immediately.
- Multiplexer: purely combinational, no clock or reset dependence.
  - selector=0: salida=a.
  - selector=1: salida=b.
  - selector X/Z: salida driven to all-X in simulation only; no latch is inferred.
- Mux output is valid within the same delta as any input change. Full DATA_W bits pass with no truncation or extension.

Decomposition:
- Shared package ctrl_pkg:
  - opcode localparams: OP_RTYPE=6'b000000, OP_LW=6'b100011, OP_SW=6'b101011, OP_BEQ=6'b000100, OP_ADDI=6'b001000.
  - AluOp encodings: ALUOP_ADD=2'b00, ALUOP_SUB=2'b01, ALUOP_FUNCT=2'b10.
- Sub-module mux2_dw (parameterised by DATA_W) holds the combinational selector and is instantiated once at top.
- The decoder stays in the top as a combinational case statement plus an output register stage.

Test Plan:
- Reset: rst_n=0 with op=000000 applied → all control outputs 0, AluOp=00, op_illegal=0, immediately and without a clock edge. Release rst_n, then one edge → RegWrite=1, AluOp=10.
- Opcode sweep: op=000000, 100011, 101011, 000100, 001000 on consecutive edges → each row of the table appears exactly one cycle after its op is applied.
- Illegal: op=111111 → after one edge all enables 0, AluOp=00, op_illegal=1. Then op=100011 → MemToReg=1, RegWrite=1, op_illegal=0.
- Reset mid-stream: with outputs showing sw (MemToWrite=1), assert rst_n=0 between edges → MemToWrite drops to 0 immediately.
- Mux: a=32'd10, b=32'd20, selector=1 → salida=20 (hold 100 ns). Then selector=0 → salida=10 with no clock required.
- Mux width: a=32'hFFFF_FFFF, b=32'h0000_0000, toggle selector → salida alternates exactly between the full 32-bit values.

Source files
------------

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - opcode, ALU-class encodings and decode helper for the main control unit
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic       mem_to_reg;
    logic       mem_to_write;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       op_illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '{
    mem_to_reg: 1'b0, mem_to_write: 1'b0, reg_write: 1'b0,
    alu_op: ALUOP_ADD, op_illegal: 1'b0
  };

  // Unknown opcodes fall back to a no-write bundle so nothing in the datapath is disturbed.
  function automatic ctrl_t decode_op(input logic [5:0] op);
    ctrl_t c;
    c = CTRL_IDLE;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        c.alu_op    = ALUOP_FUNCT;
      end
      OP_LW: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      OP_SW:   c.mem_to_write = 1'b1;
      OP_BEQ:  c.alu_op       = ALUOP_SUB;
      OP_ADDI: c.reg_write    = 1'b1;
      default: c.op_illegal   = 1'b1;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mux2_dw.sv
// rtl/mux2_dw.sv - combinational DATA_W-bit 2:1 selector
module mux2_dw #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              selector,
  output logic [DATA_W-1:0] salida
);

  // An unknown select propagates as all-X rather than silently picking an input.
  always_comb begin
    salida = '0;
    case (selector)
      1'b0:    salida = a;
      1'b1:    salida = b;
      default: salida = 'x;
    endcase
  end

endmodule

// File: rtl/unidad_de_control.sv
// rtl/unidad_de_control.sv - registered opcode decoder plus bundled 2:1 data selector
module unidad_de_control
  import ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   op,
  output logic              MemToReg,
  output logic              MemToWrite,
  output logic              RegWrite,
  output logic [1:0]        AluOp,
  output logic              op_illegal,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              selector,
  output logic [DATA_W-1:0] salida
);

  ctrl_t w_next;
  ctrl_t r_ctrl;

  always_comb begin
    w_next = decode_op(6'(op));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl <= CTRL_IDLE;
    end else begin
      r_ctrl <= w_next;
    end
  end

  assign MemToReg   = r_ctrl.mem_to_reg;
  assign MemToWrite = r_ctrl.mem_to_write;
  assign RegWrite   = r_ctrl.reg_write;
  assign AluOp      = r_ctrl.alu_op;
  assign op_illegal = r_ctrl.op_illegal;

  mux2_dw #(
    .DATA_W(DATA_W)
  ) u_mux (
    .a        (a),
    .b        (b),
    .selector (selector),
    .salida   (salida)
  );

endmodule

// File: tb/tb_unidad_de_control.sv
// tb/tb_unidad_de_control.sv - self-checking bench for the control unit and its data selector
module tb_unidad_de_control;

  logic        clk;
  logic        rst_n;
  logic [5:0]  op;
  logic        MemToReg;
  logic        MemToWrite;
  logic        RegWrite;
  logic [1:0]  AluOp;
  logic        op_illegal;
  logic [31:0] a;
  logic [31:0] b;
  logic        selector;
  logic [31:0] salida;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected rows {MemToReg, MemToWrite, RegWrite, AluOp, op_illegal}, keyed by opcode.
  logic [5:0] ref_tbl [logic [5:0]];
  logic [5:0] legal_ops [5];

  unidad_de_control #(.DATA_W(32), .OP_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .op         (op),
    .MemToReg   (MemToReg),
    .MemToWrite (MemToWrite),
    .RegWrite   (RegWrite),
    .AluOp      (AluOp),
    .op_illegal (op_illegal),
    .a          (a),
    .b          (b),
    .selector   (selector),
    .salida     (salida)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] ref_ctrl(input logic [5:0] o);
    if (ref_tbl.exists(o)) return ref_tbl[o];
    return 6'b000001;
  endfunction

  function automatic logic [5:0] ctrl_obs();
    return {MemToReg, MemToWrite, RegWrite, AluOp, op_illegal};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [5:0] v);
    logic [5:0] obs;
    @(negedge clk);
    op = v;
    @(posedge clk);
    #1;
    obs = ctrl_obs();
    chk(tag, {26'd0, obs}, {26'd0, ref_ctrl(v)});
    chk({tag, "_excl"}, {31'd0, MemToWrite & RegWrite}, 32'd0);
    chk({tag, "_illwe"}, {31'd0, op_illegal & (MemToWrite | RegWrite)}, 32'd0);
  endtask

  initial begin
    logic [5:0]  rop;
    logic [31:0] ra, rb;
    ref_tbl[6'b000000] = 6'b001100;
    ref_tbl[6'b100011] = 6'b101000;
    ref_tbl[6'b101011] = 6'b010000;
    ref_tbl[6'b000100] = 6'b000010;
    ref_tbl[6'b001000] = 6'b001000;
    legal_ops[0] = 6'b000000;
    legal_ops[1] = 6'b100011;
    legal_ops[2] = 6'b101011;
    legal_ops[3] = 6'b000100;
    legal_ops[4] = 6'b001000;

    rst_n = 1'b0;
    op = 6'b000000;
    a = '0;
    b = '0;
    selector = 1'b0;
    #3;
    chk("reset_no_edge", {26'd0, ctrl_obs()}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_regwrite", {31'd0, RegWrite}, 32'd1);
    chk("release_aluop", {30'd0, AluOp}, 32'd2);

    for (int i = 0; i < 5; i++) step("sweep", legal_ops[i]);

    step("illegal_ff", 6'b111111);
    step("after_illegal_lw", 6'b100011);

    step("pre_reset_sw", 6'b101011);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset_memwrite", {31'd0, MemToWrite}, 32'd0);
    chk("midreset_all", {26'd0, ctrl_obs()}, 32'd0);
    @(posedge clk);
    #1;
    chk("held_in_reset", {26'd0, ctrl_obs()}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) rop = legal_ops[$urandom_range(0, 4)];
      else rop = 6'($urandom);
      step("rand_op", rop);
    end

    a = 32'd10;
    b = 32'd20;
    selector = 1'b1;
    #1;
    chk("mux_sel1", salida, 32'd20);
    #100;
    chk("mux_sel1_hold", salida, 32'd20);
    selector = 1'b0;
    #1;
    chk("mux_sel0", salida, 32'd10);

    a = 32'hFFFF_FFFF;
    b = 32'h0000_0000;
    for (int i = 0; i < 6; i++) begin
      selector = ~selector;
      #1;
      chk("mux_width", salida, selector ? 32'h0000_0000 : 32'hFFFF_FFFF);
    end

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      a = ra;
      b = rb;
      selector = 1'($urandom_range(0, 1));
      #1;
      chk("mux_rand", salida, selector ? rb : ra);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
